// File: rtl/serial_pkg.sv
// Shared definitions for the serial bit link.
//  - cnt_width(): width of the receive bit counter for a given word width.
//  - state_e: receiver state encoding (StCollect for data bits, StParity for the optional parity bit).
//  - even_parity(): even parity over a word, shared with the transmit side.
package serial_pkg;

  typedef enum logic {
    StCollect = 1'b0,
    StParity  = 1'b1
  } state_e;

  // Counter must hold 0..w-1; clamp so a 1-bit result is never zero width.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w < 2) ? 1 : $clog2(w);
  endfunction

  // Parity bit that makes the total number of ones (word + parity) even.
  function automatic logic even_parity(input logic [31:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/serial_word_buffer.sv
// One-entry valid/ready holding stage for assembled words.
// A word offered while the entry is full and not being drained is dropped and flags overrun.
// Ports:
//  clk_i          clock, posedge
//  rst_i          synchronous active-high reset
//  word_i         incoming word
//  word_valid_i   word_i is a completed word this cycle
//  ready_i        consumer ready; ignored while valid_o=0
//  data_o         held word (keeps last value after it is accepted)
//  valid_o        entry full
//  overrun_o      sticky until reset; a completed word was dropped
module serial_word_buffer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [Width-1:0] word_i,
  input  logic             word_valid_i,
  input  logic             ready_i,
  output logic [Width-1:0] data_o,
  output logic             valid_o,
  output logic             overrun_o
);

  logic [Width-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             overrun_q, overrun_d;
  logic             accept;

  assign accept = valid_q & ready_i;

  always_comb begin
    data_d    = data_q;
    valid_d   = valid_q;
    overrun_d = overrun_q;
    if (word_valid_i) begin
      // Load when empty or when the held word leaves this same cycle.
      if (!valid_q || accept) begin
        data_d  = word_i;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  assign data_o    = data_q;
  assign valid_o   = valid_q;
  assign overrun_o = overrun_q;

endmodule

// File: rtl/serial_in_parallel_out_receiver.sv
// Receive end of the LSB-first serial bit link. Collects DATA_WIDTH strobed bits into a word and
// hands it to a one-entry valid/ready buffer; collection continues while the buffer is held.
// Optional feature macro: PARITY_CHECK_EN -- adds a PARITY state taking one even-parity bit per
// word and the sticky parity_err output; the word is then delivered on the parity strobe.
// Ports:
//  clk             clock, posedge
//  rst             synchronous active-high reset
//  data_in         serial bit, sampled when data_in_valid=1
//  data_in_valid   bit strobe
//  data_out        assembled word, first received bit in bit 0
//  data_out_valid  word held in output buffer
//  data_out_ready  consumer accepts when data_out_valid & data_out_ready
//  overrun         sticky; a completed word was dropped
//  parity_err      (PARITY_CHECK_EN only) sticky parity mismatch
module serial_in_parallel_out_receiver
  import serial_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  data_in,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid,
  input  logic                  data_out_ready,
  output logic                  overrun
`ifdef PARITY_CHECK_EN
  ,
  output logic                  parity_err
`endif
);

  localparam int unsigned     CntW    = cnt_width(DATA_WIDTH);
  localparam logic [CntW-1:0] LastCnt = CntW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] word;
  logic                  word_valid;
`ifdef PARITY_CHECK_EN
  logic                  parity_err_q, parity_err_d;
`endif

  always_comb begin
    shift_d    = shift_q;
    cnt_d      = cnt_q;
    state_d    = state_q;
    word_valid = 1'b0;
    // New bit enters at the MSB, so after DATA_WIDTH bits the first one sits in bit 0.
    word       = {data_in, shift_q[DATA_WIDTH-1:1]};
`ifdef PARITY_CHECK_EN
    parity_err_d = parity_err_q;
`endif
    if (data_in_valid) begin
      unique case (state_q)
        StCollect: begin
          shift_d = word;
          if (cnt_q == LastCnt) begin
            cnt_d = '0;
`ifdef PARITY_CHECK_EN
            state_d = StParity;
`else
            word_valid = 1'b1;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        StParity: begin
          state_d = StCollect;
`ifdef PARITY_CHECK_EN
          word       = shift_q;
          word_valid = 1'b1;
          if (data_in != even_parity(32'(shift_q))) parity_err_d = 1'b1;
`endif
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_q <= '0;
      cnt_q   <= '0;
      state_q <= StCollect;
    end else begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

`ifdef PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) parity_err_q <= 1'b0;
    else     parity_err_q <= parity_err_d;
  end

  assign parity_err = parity_err_q;
`endif

  serial_word_buffer #(
    .Width (DATA_WIDTH)
  ) u_buf (
    .clk_i        (clk),
    .rst_i        (rst),
    .word_i       (word),
    .word_valid_i (word_valid),
    .ready_i      (data_out_ready),
    .data_o       (data_out),
    .valid_o      (data_out_valid),
    .overrun_o    (overrun)
  );

endmodule
